// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // FSM encoding; the spare code 2'b11 is treated as IDLE by the controller.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus of the serial adder.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/fa_cell.sv
// One-bit combinational full adder shared by every bit position.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic sum,
   output logic carry
);

   // Sum is odd parity, carry is the majority of the three inputs.
   assign sum   = x ^ y ^ z;
   assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, LSB first.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   serial_add_ctrl_if.slave bus
);

   localparam int unsigned   CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             cell_sum;
   logic             cell_carry;

   fa_cell u_fa (
      .x     (a_sr[0]),
      .y     (b_sr[0]),
      .z     (carry),
      .sum   (cell_sum),
      .carry (cell_carry)
   );

   // FSM, operand/result shifters, carry flop and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         s_sr   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               s_sr  <= {cell_sum, s_sr[WIDTH-1:1]};
               carry <= cell_carry;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  sum_q  <= {cell_sum, s_sr[WIDTH-1:1]};
                  cout_q <= cell_carry;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= DONE;
               end
            end
            // IDLE, DONE and the spare code all accept a new request.
            default: begin
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  carry  <= bus.cin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_add_ctrl;

   logic clk;
   logic rst8;
   logic rst13;
   int   n_vec;
   int   n_err;

   serial_add_ctrl_if #(.WIDTH(8))  if8  ();
   serial_add_ctrl_if #(.WIDTH(13)) if13 ();

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .bus (if8)
   );

   serial_add_ctrl #(.WIDTH(13)) u_dut13 (
      .clk (clk),
      .rst (rst13),
      .bus (if13)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input bit w13, input logic st, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      if (w13) begin
         if13.start = st;
         if13.a     = a[12:0];
         if13.b     = b[12:0];
         if13.cin   = c;
      end else begin
         if8.start  = st;
         if8.a      = a[7:0];
         if8.b      = b[7:0];
         if8.cin    = c;
      end
   endtask

   task automatic sample(input bit w13, output logic bz, output logic dn, output logic [31:0] s,
                         output logic co);
      if (w13) begin
         bz = if13.busy; dn = if13.done; s = 32'(if13.sum); co = if13.cout;
      end else begin
         bz = if8.busy;  dn = if8.done;  s = 32'(if8.sum);  co = if8.cout;
      end
   endtask

   // One full operation; called on a falling edge with start low.
   task automatic run_op(input bit w13, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input string tag);
      int          w;
      int          k;
      int          busy_n;
      bit          got;
      logic [32:0] full;
      logic [31:0] exp_s;
      logic        exp_c;
      logic        bz, dn, co;
      logic [31:0] s;
      w     = w13 ? 13 : 8;
      full  = 33'(a) + 33'(b) + 33'(c);
      exp_s = full[31:0] & ((32'd1 << w) - 32'd1);
      exp_c = full[w];
      drive(w13, 1'b1, a, b, c);
      @(posedge clk);
      @(negedge clk);
      drive(w13, 1'b0, $urandom, $urandom, 1'($urandom));
      got = 0; busy_n = 0; k = 0;
      bz = 0; dn = 0; s = 0; co = 0;
      while (!got && k <= 3 * w) begin
         sample(w13, bz, dn, s, co);
         if (dn) got = 1;
         else begin
            if (bz) busy_n++;
            k++;
            @(negedge clk);
         end
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL %s timeout: no done within %0d cycles", tag, 3 * w);
         return;
      end
      n_vec++;
      if (k !== w) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", tag, k, w);
      end
      n_vec++;
      if (busy_n !== w) begin
         n_err++;
         $display("FAIL %s busy_len: got %0d cycles, expected %0d", tag, busy_n, w);
      end
      n_vec++;
      if (bz !== 1'b0) begin
         n_err++;
         $display("FAIL %s busy_with_done: got %b, expected 0", tag, bz);
      end
      n_vec++;
      if (s !== exp_s || co !== exp_c) begin
         n_err++;
         $display("FAIL %s result a=%h b=%h cin=%b: got cout=%b sum=%h, expected cout=%b sum=%h",
                  tag, a, b, c, co, s, exp_c, exp_s);
      end
   endtask

   task automatic test_reset();
      rst8 = 1'b1; rst13 = 1'b1;
      drive(0, 1'b0, 0, 0, 1'b0);
      drive(1, 1'b0, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      n_vec++;
      if ({if8.busy, if8.done, if8.sum, if8.cout} !== '0) begin
         n_err++;
         $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, expected all 0",
                  if8.busy, if8.done, if8.sum, if8.cout);
      end
      n_vec++;
      if ({if13.busy, if13.done, if13.sum, if13.cout} !== '0) begin
         n_err++;
         $display("FAIL reset13: got busy=%b done=%b sum=%h cout=%b, expected all 0",
                  if13.busy, if13.done, if13.sum, if13.cout);
      end
      rst8 = 1'b0; rst13 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_op(0, 32'h3C, 32'h5A, 1'b0, "basic");
      @(negedge clk);
   endtask

   task automatic test_carry();
      run_op(0, 32'hFF, 32'h01, 1'b0, "carry_ff_01");
      @(negedge clk);
      run_op(0, 32'hFF, 32'hFF, 1'b1, "carry_ff_ff_1");
      @(negedge clk);
   endtask

   task automatic test_ignored_start();
      int          pulses;
      int          first_k;
      logic [7:0]  first_sum;
      pulses = 0; first_k = -1; first_sum = '0;
      drive(0, 1'b1, 32'h3C, 32'h5A, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 24; k++) begin
         if (k == 3) drive(0, 1'b1, 32'h11, 32'h00, 1'b1);
         if (k == 4) drive(0, 1'b0, 0, 0, 1'b0);
         if (if8.done) begin
            pulses++;
            if (first_k < 0) begin
               first_k   = k;
               first_sum = if8.sum;
            end
         end
         @(negedge clk);
      end
      n_vec++;
      if (pulses !== 1) begin
         n_err++;
         $display("FAIL ign_start_pulses: got %0d done pulses, expected 1", pulses);
      end
      n_vec++;
      if (first_k !== 8 || first_sum !== 8'h96) begin
         n_err++;
         $display("FAIL ign_start_result: got done at %0d sum=%h, expected 8 sum=96",
                  first_k, first_sum);
      end
   endtask

   // Start held high: each result takes 8 busy cycles plus the DONE cycle.
   task automatic test_back_to_back();
      int bad;
      bad = 0;
      drive(0, 1'b1, 32'h01, 32'h02, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b1, 32'h10, 32'h20, 1'b0);
      for (int k = 0; k <= 17; k++) begin
         if (k == 8) begin
            n_vec++;
            if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.sum !== 8'h03 || if8.cout !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_first: got done=%b busy=%b sum=%h cout=%b, expected 1 0 03 0",
                        if8.done, if8.busy, if8.sum, if8.cout);
            end
         end else if (k == 17) begin
            n_vec++;
            if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.sum !== 8'h30 || if8.cout !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_second: got done=%b busy=%b sum=%h cout=%b, expected 1 0 30 0",
                        if8.done, if8.busy, if8.sum, if8.cout);
            end
            drive(0, 1'b0, 0, 0, 1'b0);
         end else if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
            bad++;
         end
         @(negedge clk);
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL b2b_busy: got %0d cycles with busy low or done high outside DONE, expected 0",
                  bad);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int pulses;
      pulses = 0;
      drive(0, 1'b1, 32'h0F, 32'h01, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      #1;
      n_vec++;
      if ({if8.busy, if8.done, if8.sum, if8.cout} !== '0) begin
         n_err++;
         $display("FAIL mid_reset_outputs: got busy=%b done=%b sum=%h cout=%b, expected all 0",
                  if8.busy, if8.done, if8.sum, if8.cout);
      end
      @(negedge clk);
      rst8 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (if8.done) pulses++;
         @(negedge clk);
      end
      n_vec++;
      if (pulses !== 0) begin
         n_err++;
         $display("FAIL mid_reset_no_done: got %0d done pulses, expected 0", pulses);
      end
      run_op(0, 32'h0F, 32'h01, 1'b0, "after_reset");
      @(negedge clk);
   endtask

   task automatic test_random(input bit w13);
      logic [31:0] mask;
      mask = w13 ? 32'h1FFF : 32'hFF;
      for (int i = 0; i < 1000; i++) begin
         run_op(w13, $urandom & mask, $urandom & mask, 1'($urandom), w13 ? "rand13" : "rand8");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_carry();
      test_ignored_start();
      test_back_to_back();
      test_mid_reset();
      test_random(0);
      test_random(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
